// File: rtl/rr_mux_sel_sched.sv
// Round-robin select scheduler for a downstream 4:1 channel mux.
// Holds each winning channel for DWELL accepted beats (or until its request drops),
// then rotates priority to the channel after the one just served.
module rr_mux_sel_sched #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       last
);

  // Reject dwell values the beat counter cannot represent.
  if (DWELL < 1 || DWELL > (1 << CNT_W)) begin : g_bad_dwell
    $error("rr_mux_sel_sched: illegal DWELL=%0d for CNT_W=%0d", DWELL, CNT_W);
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [1:0] next_ptr;
  logic [1:0] win_idle;
  logic [1:0] win_end;
  logic       xfer;
  logic       end_full;
  logic       abandon;

  // First set request scanning from p upward, modulo 4.
  function automatic logic [1:0] arb(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] idx;
    w = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  // Arbitration results and grant-termination conditions.
  always_comb begin
    next_ptr = sel_q + 2'd1;
    win_idle = arb(req, ptr_q);
    win_end  = arb(req, next_ptr);
    xfer     = valid_q && ready;
    end_full = xfer && (cnt_q == CntLast);
    abandon  = !req[sel_q];
  end

  // Next-state logic: IDLE waits for any request, GRANT counts beats and rotates.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (req != 4'b0000) begin
          state_d = StGrant;
          sel_d   = win_idle;
          gnt_d   = 4'b0001 << win_idle;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          valid_d = 1'b0;
          gnt_d   = 4'b0000;
        end
      end
      StGrant: begin
        // A full-dwell transfer takes precedence over a simultaneous abandon.
        if (end_full || abandon) begin
          ptr_d = next_ptr;
          cnt_d = '0;
          if (req != 4'b0000) begin
            sel_d   = win_end;
            gnt_d   = 4'b0001 << win_end;
            valid_d = 1'b1;
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
            gnt_d   = 4'b0000;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign last  = valid_q && (cnt_q == CntLast);

endmodule

// File: tb/tb_rr_mux_sel_sched.sv
// Directed bench for rr_mux_sel_sched: one instance at DWELL=4, one at DWELL=2,
// sharing clock, reset and stimulus.
module tb_rr_mux_sel_sched;

  localparam int unsigned CW = 3;
  localparam int unsigned D4 = 4;
  localparam int unsigned D2 = 2;

  if (D4 < 1 || D4 > (1 << CW)) begin : g_bad_d4
    $error("tb: illegal DWELL=%0d for CNT_W=%0d", D4, CW);
  end
  if (D2 < 1 || D2 > (1 << CW)) begin : g_bad_d2
    $error("tb: illegal DWELL=%0d for CNT_W=%0d", D2, CW);
  end

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ready;

  logic [1:0] d4_sel, d2_sel;
  logic [3:0] d4_gnt, d2_gnt;
  logic       d4_valid, d2_valid, d4_last, d2_last;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_mux_sel_sched #(.DWELL(D4), .CNT_W(CW)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .sel(d4_sel), .gnt(d4_gnt), .valid(d4_valid), .last(d4_last)
  );

  rr_mux_sel_sched #(.DWELL(D2), .CNT_W(CW)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .sel(d2_sel), .gnt(d2_gnt), .valid(d2_valid), .last(d2_last)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [1:0] es, input logic [3:0] eg,
                      input logic ev, input logic el);
    chk({tag, ".d4.sel"}, 8'(d4_sel), 8'(es));
    chk({tag, ".d4.gnt"}, 8'(d4_gnt), 8'(eg));
    chk({tag, ".d4.valid"}, 8'(d4_valid), 8'(ev));
    chk({tag, ".d4.last"}, 8'(d4_last), 8'(el));
  endtask

  task automatic chk2(input string tag, input logic [1:0] es, input logic [3:0] eg,
                      input logic ev, input logic el);
    chk({tag, ".d2.sel"}, 8'(d2_sel), 8'(es));
    chk({tag, ".d2.gnt"}, 8'(d2_gnt), 8'(eg));
    chk({tag, ".d2.valid"}, 8'(d2_valid), 8'(ev));
    chk({tag, ".d2.last"}, 8'(d2_last), 8'(el));
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] es;

    // Reset with all requests high.
    rst = 1'b1; req = 4'b1111; ready = 1'b1;
    tick(); chk4("rst0", 2'd0, 4'b0000, 1'b0, 1'b0); chk2("rst0", 2'd0, 4'b0000, 1'b0, 1'b0);
    tick(); chk4("rst1", 2'd0, 4'b0000, 1'b0, 1'b0); chk2("rst1", 2'd0, 4'b0000, 1'b0, 1'b0);

    // Single requester ch2, DWELL=4: last on 4th beat, then back-to-back re-grant.
    rst = 1'b0; req = 4'b0100;
    tick(); chk4("c2.b0", 2'd2, 4'b0100, 1'b1, 1'b0);
    tick(); chk4("c2.b1", 2'd2, 4'b0100, 1'b1, 1'b0);
    tick(); chk4("c2.b2", 2'd2, 4'b0100, 1'b1, 1'b0);
    tick(); chk4("c2.b3", 2'd2, 4'b0100, 1'b1, 1'b1);
    tick(); chk4("c2.regrant", 2'd2, 4'b0100, 1'b1, 1'b0);

    // All requesting, DWELL=2: sel 0,0,1,1,2,2,3,3,0 with continuous valid.
    rst = 1'b1; tick(); rst = 1'b0; req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      tick();
      es = 2'((k / 2) % 4);
      chk2($sformatf("rot%0d", k), es, 4'b0001 << es, 1'b1, (k % 2) == 1);
    end

    // Ch1 grant with a 5-cycle stall after one beat; three more beats finish it.
    rst = 1'b1; tick(); rst = 1'b0; req = 4'b0010; ready = 1'b0;
    tick(); chk4("st.grant", 2'd1, 4'b0010, 1'b1, 1'b0);
    ready = 1'b1; req = 4'b0011;
    tick(); chk4("st.b1", 2'd1, 4'b0010, 1'b1, 1'b0);
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(); chk4($sformatf("st.hold%0d", k), 2'd1, 4'b0010, 1'b1, 1'b0);
    end
    ready = 1'b1;
    tick(); chk4("st.b2", 2'd1, 4'b0010, 1'b1, 1'b0);
    tick(); chk4("st.b3", 2'd1, 4'b0010, 1'b1, 1'b1);
    tick(); chk4("st.next", 2'd0, 4'b0001, 1'b1, 1'b0);

    // Abandon ch0 at cnt=1 in favour of ch3; ptr wraps to 0 after ch3 completes.
    rst = 1'b1; tick(); rst = 1'b0; req = 4'b0001; ready = 1'b1;
    tick(); chk4("ab.grant", 2'd0, 4'b0001, 1'b1, 1'b0);
    tick(); chk4("ab.b1", 2'd0, 4'b0001, 1'b1, 1'b0);
    req = 4'b1000;
    tick(); chk4("ab.ch3", 2'd3, 4'b1000, 1'b1, 1'b0);
    req = 4'b1001;
    tick(); chk4("ab.c1", 2'd3, 4'b1000, 1'b1, 1'b0);
    tick(); chk4("ab.c2", 2'd3, 4'b1000, 1'b1, 1'b0);
    tick(); chk4("ab.c3", 2'd3, 4'b1000, 1'b1, 1'b1);
    tick(); chk4("ab.wrap", 2'd0, 4'b0001, 1'b1, 1'b0);

    // Reset mid-grant at cnt=2, then ptr must be back at 0.
    rst = 1'b1; tick(); rst = 1'b0; req = 4'b0100;
    tick(); tick(); tick();
    chk4("mr.cnt2", 2'd2, 4'b0100, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); chk4("mr.rst", 2'd0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0; req = 4'b0010;
    tick(); chk4("mr.ch1", 2'd1, 4'b0010, 1'b1, 1'b0);

    // Request drops to zero: abandon into IDLE, sel holds.
    req = 4'b0000;
    tick(); chk4("idle.drop", 2'd1, 4'b0000, 1'b0, 1'b0);
    tick(); chk4("idle.hold", 2'd1, 4'b0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
